// File: rtl/configure.sv
// Shared build constants: baud divider, UART status bit positions and UART FSM state types.
package configure;

   localparam int unsigned clks_per_bit = 433;

   localparam int unsigned uart_rx_data_lsb  = 0;
   localparam int unsigned uart_rx_valid_bit = 8;
   localparam int unsigned uart_tx_busy_bit  = 9;
   localparam int unsigned uart_overrun_bit  = 10;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } uart_tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, start-bit glitch reject, mid-bit sampling.
// Emits a one-cycle strobe with the byte when a frame ends with a valid stop bit.
module uart_rx
   import configure::*;
#(
   parameter int unsigned CLKS_PER_BIT = clks_per_bit
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       i_rx,
   output logic       o_valid,
   output logic [7:0] o_data
);

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned HALF = CLKS_PER_BIT / 2;

   // [0],[1] form the synchronizer; [2] holds the previous synced level for edge detection
   logic [2:0]     r_sync;
   logic [CW-1:0]  r_cnt;
   logic [2:0]     r_bit;
   logic [7:0]     r_shift;
   uart_rx_state_t r_state;
   logic           w_line;

   assign w_line = r_sync[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync  <= '1;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_state <= RX_IDLE;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         r_sync  <= {r_sync[1:0], i_rx};
         o_valid <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               r_cnt <= '0;
               r_bit <= '0;
               if (r_sync[2] && !w_line) r_state <= RX_START;
            end
            RX_START: begin
               if (r_cnt == CW'(HALF - 1)) begin
                  r_cnt   <= '0;
                  r_state <= w_line ? RX_IDLE : RX_DATA;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            RX_DATA: begin
               if (r_cnt == CW'(CLKS_PER_BIT)) begin
                  r_cnt   <= '0;
                  r_shift <= {w_line, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) r_state <= RX_STOP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            RX_STOP: begin
               if (r_cnt == CW'(CLKS_PER_BIT)) begin
                  r_cnt   <= '0;
                  r_state <= RX_IDLE;
                  if (w_line) begin
                     o_valid <= 1'b1;
                     o_data  <= r_shift;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart.sv
// Memory-mapped 8N1 UART: writes send a byte (stalling while TX busy),
// reads return {overrun, tx_busy, rx_valid, rx_data} and clear the RX flags.
module uart
   import configure::*;
#(
   parameter int unsigned CLKS_PER_BIT = clks_per_bit
) (
   input  logic        reset,
   input  logic        clock,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   input  logic        uart_rx,
   output logic        uart_tx
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

   uart_tx_state_t r_tx_state;
   logic [CW-1:0]  r_tx_cnt;
   logic [2:0]     r_tx_bit;
   logic [7:0]     r_tx_shift;
   logic [7:0]     r_rx_data;
   logic           r_rx_valid;
   logic           r_overrun;

   logic        w_tx_busy;
   logic        w_req;
   logic        w_wr;
   logic        w_rd;
   logic        w_rx_strobe;
   logic [7:0]  w_rx_byte;
   logic [31:0] w_status;
   logic        w_unused;

   assign w_unused  = &{1'b0, mem_addr, mem_wdata[31:8]};
   assign w_tx_busy = (r_tx_state != TX_IDLE);
   assign w_req     = mem_valid && !mem_ready;
   assign w_wr      = w_req && (mem_wstrb != 4'h0) && !w_tx_busy;
   assign w_rd      = w_req && (mem_wstrb == 4'h0);

   always_comb begin
      w_status = '0;
      w_status[uart_rx_data_lsb +: 8] = r_rx_data;
      w_status[uart_rx_valid_bit]     = r_rx_valid;
      w_status[uart_tx_busy_bit]      = w_tx_busy;
      w_status[uart_overrun_bit]      = r_overrun;
   end

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clock   (clock),
      .reset   (reset),
      .i_rx    (uart_rx),
      .o_valid (w_rx_strobe),
      .o_data  (w_rx_byte)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_ready  <= 1'b0;
         mem_rdata  <= '0;
         uart_tx    <= 1'b1;
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         mem_ready <= w_wr || w_rd;
         if (w_rd) begin
            mem_rdata  <= w_status;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
         end
         // a byte landing in the same cycle as a read wins and is not an overrun
         if (w_rx_strobe) begin
            r_rx_data  <= w_rx_byte;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !w_rd) r_overrun <= 1'b1;
         end

         case (r_tx_state)
            TX_IDLE: begin
               uart_tx  <= 1'b1;
               r_tx_cnt <= '0;
               if (w_wr) begin
                  r_tx_shift <= mem_wdata[7:0];
                  uart_tx    <= 1'b0;
                  r_tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (r_tx_cnt == CW'(CLKS_PER_BIT)) begin
                  r_tx_cnt   <= '0;
                  r_tx_bit   <= '0;
                  uart_tx    <= r_tx_shift[0];
                  r_tx_state <= TX_DATA;
               end else begin
                  r_tx_cnt <= r_tx_cnt + CW'(1);
               end
            end
            TX_DATA: begin
               if (r_tx_cnt == CW'(CLKS_PER_BIT)) begin
                  r_tx_cnt   <= '0;
                  r_tx_shift <= r_tx_shift >> 1;
                  if (r_tx_bit == 3'd7) begin
                     uart_tx    <= 1'b1;
                     r_tx_state <= TX_STOP;
                  end else begin
                     r_tx_bit <= r_tx_bit + 3'd1;
                     uart_tx  <= r_tx_shift[1];
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + CW'(1);
               end
            end
            TX_STOP: begin
               if (r_tx_cnt == CW'(CLKS_PER_BIT)) begin
                  r_tx_cnt   <= '0;
                  r_tx_state <= TX_IDLE;
               end else begin
                  r_tx_cnt <= r_tx_cnt + CW'(1);
               end
            end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: bus responses and TX frames checked against a behavioural model.
module tb_uart;

   localparam int CPB = 3;
   localparam int BIT = CPB + 1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        uart_rx = 1'b1;
   logic        uart_tx;

   uart #(.CLKS_PER_BIT(CPB)) dut (
      .reset     (reset),
      .clock     (clock),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .uart_rx   (uart_rx),
      .uart_tx   (uart_tx)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      bit          is_read;
      logic [31:0] rdata;
      string       name;
   } sb_t;

   sb_t        sb_q[$];
   logic [7:0] tx_q[$];

   // behavioural register model
   logic [7:0] m_data  = '0;
   bit         m_valid = 1'b0;
   bit         m_ovr   = 1'b0;
   bit         tx_abort = 1'b0;

   function automatic logic [39:0] frame_pattern(input logic [7:0] b);
      logic [9:0]  f;
      logic [39:0] p;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 40; i++) p[i] = f[i / BIT];
      return p;
   endfunction

   // bus response monitor
   always @(negedge clock) begin
      if (mem_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL ready_unexpected: got mem_ready=1, expected no pending request");
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            if (e.is_read) check(e.name, mem_rdata, e.rdata);
         end
      end
   end

   // TX line monitor: captures 40 clocks per frame
   int          tx_n = 0;
   logic [39:0] tx_samp;
   always @(negedge clock) begin
      if (tx_n > 0 && tx_abort) begin
         tx_n = 0;
         tx_abort = 1'b0;
         if (tx_q.size() > 0) void'(tx_q.pop_front());
      end else if (tx_n == 0 && uart_tx === 1'b0) begin
         tx_samp[0] = 1'b0;
         tx_n = 1;
      end else if (tx_n > 0) begin
         tx_samp[tx_n] = uart_tx;
         tx_n++;
         if (tx_n == 40) begin
            tx_n = 0;
            if (tx_q.size() == 0) begin
               n_checks++;
               $display("FAIL tx_frame: got frame 0x%0h, expected no frame", tx_samp);
            end else begin
               check("tx_frame", tx_samp, frame_pattern(tx_q.pop_front()));
            end
         end
      end
   end

   task automatic bus_op(input bit wr, input logic [7:0] b, input logic [31:0] exp,
                         input string name, input int exp_lat, output int ready_cyc);
      sb_t e;
      int  lat;
      lat = 0;
      @(negedge clock);
      while (mem_ready) @(negedge clock);
      mem_valid = 1'b1;
      mem_wstrb = wr ? 4'($urandom_range(1, 15)) : 4'h0;
      mem_wdata = {24'($urandom), b};
      mem_addr  = $urandom;
      e.is_read = !wr;
      e.rdata   = exp;
      e.name    = name;
      sb_q.push_back(e);
      if (wr) tx_q.push_back(b);
      do begin
         @(posedge clock);
         #1;
         lat++;
      end while (!mem_ready && lat < 200);
      ready_cyc = cyc;
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      if (exp_lat > 0 || lat >= 200) check({name, "_latency"}, 64'(lat), 64'(exp_lat));
   endtask

   task automatic do_read(input bit busy, input string name);
      logic [31:0] e;
      int          rc;
      e = {21'b0, m_ovr, busy, m_valid, m_data};
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      bus_op(1'b0, 8'h00, e, name, 1, rc);
   endtask

   task automatic do_write(input logic [7:0] b, input string name, input int exp_lat, output int rc);
      bus_op(1'b1, b, 32'h0, name, exp_lat, rc);
   endtask

   task automatic send_rx(input logic [7:0] b, input bit stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         uart_rx = f[i];
         repeat (BIT - 1) @(negedge clock);
      end
      @(negedge clock);
      uart_rx = 1'b1;
      repeat (12) @(negedge clock);
      if (stop) begin
         if (m_valid) m_ovr = 1'b1;
         m_valid = 1'b1;
         m_data  = b;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: got no finish, expected finish within 2ms");
      $fatal(1, "timeout");
   end

   initial begin
      int rc, rc1, rc2;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("reset_tx", uart_tx, 1);
      check("reset_ready", mem_ready, 0);
      check("reset_rdata", mem_rdata, 0);
      @(negedge clock);
      reset = 1'b0;
      do_read(1'b0, "rd_reset");

      do_write(8'hA5, "wr_a5", 1, rc);
      repeat (45) @(negedge clock);

      do_write(8'h55, "wr_55", 1, rc1);
      do_read(1'b1, "rd_busy");
      do_write(8'h0F, "wr_0f", -1, rc2);
      check("b2b_ready_gap", 64'(rc2 - rc1), 64'(41));
      repeat (45) @(negedge clock);

      send_rx(8'h3C, 1'b1);
      do_read(1'b0, "rd_3c");
      do_read(1'b0, "rd_3c_again");

      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      send_rx(8'h33, 1'b0);
      do_read(1'b0, "rd_overrun");
      do_read(1'b0, "rd_after_overrun");

      @(negedge clock);
      uart_rx = 1'b0;
      @(negedge clock);
      uart_rx = 1'b1;
      repeat (20) @(negedge clock);
      do_read(1'b0, "rd_glitch");

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 2))
            0: begin
               do_write(8'($urandom), "rnd_wr", 1, rc);
               if ($urandom_range(0, 1) == 1) begin
                  repeat (5) @(negedge clock);
                  do_read(1'b1, "rnd_rd_busy");
               end
               repeat (48) @(negedge clock);
            end
            1: send_rx(8'($urandom), $urandom_range(0, 5) != 0);
            default: do_read(1'b0, "rnd_rd");
         endcase
      end

      do_write(8'($urandom), "wr_before_reset", 1, rc);
      repeat (15) @(negedge clock);
      tx_abort = 1'b1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("rst_mid_tx_line", uart_tx, 1);
      check("rst_mid_tx_ready", mem_ready, 0);
      @(negedge clock);
      reset = 1'b0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      do_read(1'b0, "rd_after_reset");

      repeat (50) @(negedge clock);
      check("sb_drained", 64'(sb_q.size()), 0);
      check("tx_q_drained", 64'(tx_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
